mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_pick2.sv | 27 ++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break (default: data wins).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [31:0] MMIO_BASE_MEMORY_DEF = 32'h8000_0000;
  localparam logic [31:0] MMIO_MASK_MEMORY_DEF = 32'hFFFF_FF00;

  // Outside the decoded window, or not word aligned.
  function automatic logic addr_is_bad(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] mask);
    return ((addr & mask) != base) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/mem_arb_pick2.sv
// Two-way tie-break: one-hot grant (bit0 = instruction, bit1 = data).
// Build option: MEM_ARB_ROUND_ROBIN_EN adds the last-grant input and alternates on ties.
module mem_arb_pick2
  import mem_arb_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic       last_grant,
`endif
  output logic [1:0] grant
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    grant = {req_d, req_i};
    if (req_i && req_d) begin
      grant = (last_grant == OWN_D) ? 2'b01 : 2'b10;
    end
  end
`else
  always_comb begin
    grant = {req_d, req_i & ~req_d};
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one memory port.
// Build option: MEM_ARB_ROUND_ROBIN_EN (round-robin ties; otherwise data always wins).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] MMIO_BASE_MEMORY = MMIO_BASE_MEMORY_DEF,
  parameter logic [31:0] MMIO_MASK_MEMORY = MMIO_MASK_MEMORY_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic        rw_q, rw_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [1:0]  grant;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_e      last_grant_q, last_grant_d;

  mem_arb_pick2 u_pick (
    .req_i      (i_req),
    .req_d      (d_req),
    .last_grant (last_grant_q),
    .grant      (grant)
  );
`else
  mem_arb_pick2 u_pick (
    .req_i (i_req),
    .req_d (d_req),
    .grant (grant)
  );
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          if (grant[1]) begin
            owner_d = OWN_D;
            rw_d    = d_rw;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            owner_d = OWN_I;
            rw_d    = 1'b0;
            addr_d  = i_addr;
            wdata_d = '0;
          end
          err_d   = addr_is_bad(addr_d, MMIO_BASE_MEMORY, MMIO_MASK_MEMORY);
          // A rejected address skips the memory cycle entirely.
          state_d = err_d ? RESP : ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = owner_d;
`endif
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= OWN_I;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Outputs decode straight from state so reset clears them without a clock.
  logic        in_resp;
  logic [31:0] resp_rdata;

  assign mem_en     = (state_q == ACCESS);
  assign mem_rw     = mem_en & rw_q;
  assign mem_addr   = mem_en ? addr_q  : '0;
  assign mem_wdata  = mem_en ? wdata_q : '0;

  assign in_resp    = (state_q == RESP);
  assign resp_rdata = (in_resp && !rw_q && !err_q) ? mem_rdata : '0;

  assign i_ack   = in_resp && (owner_q == OWN_I);
  assign i_err   = i_ack & err_q;
  assign i_rdata = i_ack ? resp_rdata : '0;
  assign d_ack   = in_resp && (owner_q == OWN_D);
  assign d_err   = d_ack & err_q;
  assign d_rdata = d_ack ? resp_rdata : '0;

  assign busy = (state_q != IDLE);

endmodule
